// File: rtl/data_mem_arbiter_if.sv
// Request/grant bus between the two data-memory masters, the arbiter and the
// single-ported data memory. The arbiter uses the slave modport.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              m0_req;
    logic              m0_we;
    logic [MASK_W-1:0] m0_mask;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [MASK_W-1:0] m1_mask;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_request;
    logic              mem_we_re;
    logic [MASK_W-1:0] mem_mask;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  m0_req, m0_we, m0_mask, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_mask, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_request, mem_we_re, mem_mask, mem_address, mem_data_in,
        input  mem_data_out
    );

    modport master (
        output m0_req, m0_we, m0_mask, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_mask, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_request, mem_we_re, mem_mask, mem_address, mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory (LSU = port 0).
// Define DMEM_ARB_RR_EN for round-robin contention; default is fixed priority to port 0.
module data_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    data_mem_arbiter_if.slave bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              cmd_port;
    logic              cmd_we;
    logic [MASK_W-1:0] cmd_mask;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              any_req;
    logic              winner;
    logic              sel_we;
    logic [MASK_W-1:0] sel_mask;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
    logic              rr_ptr;
`endif

    // A lone requester always wins; only contention consults the policy.
    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
`ifdef DMEM_ARB_RR_EN
        if (bus.m0_req && bus.m1_req) begin
            winner = rr_ptr;
        end else begin
            winner = ~bus.m0_req;
        end
`else
        winner = ~bus.m0_req;
`endif
        sel_we    = winner ? bus.m1_we    : bus.m0_we;
        sel_mask  = winner ? bus.m1_mask  : bus.m0_mask;
        sel_addr  = winner ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = winner ? bus.m1_wdata : bus.m0_wdata;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = cmd_we ? IDLE : RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The command is captured once in IDLE, so a requester that misbehaves
    // afterwards cannot corrupt the access already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_port  <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_mask  <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (state == IDLE && any_req) begin
            cmd_port  <= winner;
            cmd_we    <= sel_we;
            cmd_mask  <= sel_mask;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (state == IDLE && any_req) begin
            rr_ptr <= ~winner;
        end
    end
`endif

    assign bus.mem_request = (state == ISSUE);
    assign bus.mem_we_re   = (state == ISSUE) & cmd_we;
    assign bus.mem_mask    = cmd_mask;
    assign bus.mem_address = cmd_addr;
    assign bus.mem_data_in = cmd_wdata;

    assign bus.m0_gnt      = (state == ISSUE) & ~cmd_port;
    assign bus.m1_gnt      = (state == ISSUE) &  cmd_port;
    assign bus.m0_rvalid   = (state == RESP)  & ~cmd_port;
    assign bus.m1_rvalid   = (state == RESP)  &  cmd_port;
    assign bus.m0_rdata    = bus.mem_data_out;
    assign bus.m1_rdata    = bus.mem_data_out;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small behavioural data memory.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_data_mem_arbiter;
    logic clk;
    logic rst;
    int   testCount;
    int   failCount;

    logic [31:0] mem [256];

    data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-ported memory: writes honour the byte mask, reads return next cycle.
    always @(posedge clk) begin
        if (bus.mem_request) begin
            if (bus.mem_we_re) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_mask[b]) mem[bus.mem_address][8*b +: 8] = bus.mem_data_in[8*b +: 8];
                end
            end else begin
                bus.mem_data_out <= mem[bus.mem_address];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit port, input bit we, input logic [3:0] mask,
                                 input logic [7:0] addr, input logic [31:0] wdata);
        if (port) begin
            bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_mask = mask;
            bus.m1_addr = addr; bus.m1_wdata = wdata;
        end else begin
            bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_mask = mask;
            bus.m0_addr = addr; bus.m0_wdata = wdata;
        end
    endtask

    task automatic releaseReq(input bit port);
        if (port) bus.m1_req = 1'b0;
        else      bus.m0_req = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_gnt"},    {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
        checkOutput({tag, "_rvalid"}, {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
        checkOutput({tag, "_memreq"}, {31'd0, bus.mem_request}, 32'd0);
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst = 1'b1;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_mask = 4'h0; bus.m0_addr = 8'h00; bus.m0_wdata = 32'h0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_mask = 4'h0; bus.m1_addr = 8'h00; bus.m1_wdata = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'hAABBCCDD;
        mem[8'h30] = 32'h12345678;

        // Reset held with both ports requesting: everything stays quiet.
        tick();
        applyStimulus(1'b0, 1'b0, 4'hF, 8'h10, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'hF, 8'h30, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkQuiet("rst_hold");
            checkOutput("rst_we",    {31'd0, bus.mem_we_re}, 32'd0);
            checkOutput("rst_mask",  {28'd0, bus.mem_mask}, 32'd0);
            checkOutput("rst_addr",  {24'd0, bus.mem_address}, 32'd0);
            checkOutput("rst_wdata", bus.mem_data_in, 32'd0);
        end
        rst = 1'b0;

        // First grant after release goes to port 0, then port 1 follows.
        tick();
        checkOutput("rel_m0_gnt", {31'd0, bus.m0_gnt}, 32'd1);
        checkOutput("rel_m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
        checkOutput("rel_addr",   {24'd0, bus.mem_address}, 32'h10);
        releaseReq(1'b0);
        tick();
        checkOutput("rel_m0_rvalid", {31'd0, bus.m0_rvalid}, 32'd1);
        checkOutput("rel_m0_rdata",  bus.m0_rdata, 32'hDEADBEEF);
        checkOutput("rel_m1_rvalid", {31'd0, bus.m1_rvalid}, 32'd0);
        tick();
        checkQuiet("rel_idle");
        tick();
        checkOutput("rel_m1_gnt2", {31'd0, bus.m1_gnt}, 32'd1);
        checkOutput("rel_addr2",   {24'd0, bus.mem_address}, 32'h30);
        releaseReq(1'b1);
        tick();
        checkOutput("rel_m1_rvalid", {31'd0, bus.m1_rvalid}, 32'd1);
        checkOutput("rel_m1_rdata",  bus.m1_rdata, 32'h12345678);
        tick();

        // Single read on port 0.
        applyStimulus(1'b0, 1'b0, 4'hF, 8'h10, 32'h0);
        tick();
        checkOutput("rd_gnt",    {31'd0, bus.m0_gnt}, 32'd1);
        checkOutput("rd_memreq", {31'd0, bus.mem_request}, 32'd1);
        checkOutput("rd_we",     {31'd0, bus.mem_we_re}, 32'd0);
        checkOutput("rd_addr",   {24'd0, bus.mem_address}, 32'h10);
        releaseReq(1'b0);
        tick();
        checkOutput("rd_memreq_off", {31'd0, bus.mem_request}, 32'd0);
        checkOutput("rd_rvalid",     {31'd0, bus.m0_rvalid}, 32'd1);
        checkOutput("rd_rdata",      bus.m0_rdata, 32'hDEADBEEF);
        tick();

        // Masked write on port 1, then read it back.
        applyStimulus(1'b1, 1'b1, 4'b0011, 8'h20, 32'h11223344);
        tick();
        checkOutput("wr_gnt",   {31'd0, bus.m1_gnt}, 32'd1);
        checkOutput("wr_we",    {31'd0, bus.mem_we_re}, 32'd1);
        checkOutput("wr_mask",  {28'd0, bus.mem_mask}, 32'h3);
        checkOutput("wr_addr",  {24'd0, bus.mem_address}, 32'h20);
        checkOutput("wr_wdata", bus.mem_data_in, 32'h11223344);
        releaseReq(1'b1);
        tick();
        checkQuiet("wr_after");
        applyStimulus(1'b1, 1'b0, 4'hF, 8'h20, 32'h0);
        tick();
        checkOutput("rb_gnt", {31'd0, bus.m1_gnt}, 32'd1);
        releaseReq(1'b1);
        tick();
        checkOutput("rb_rvalid", {31'd0, bus.m1_rvalid}, 32'd1);
        checkOutput("rb_rdata",  bus.m1_rdata, 32'hAABB3344);
        tick();

        // Continuous contention for eight cycles; grant pattern depends on policy.
        applyStimulus(1'b0, 1'b0, 4'hF, 8'h10, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'hF, 8'h30, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            logic exp0;
            logic exp1;
            tick();
`ifdef DMEM_ARB_RR_EN
            exp0 = (c == 1) || (c == 7);
            exp1 = (c == 4);
`else
            exp0 = (c % 3) == 1;
            exp1 = 1'b0;
`endif
            checkOutput($sformatf("cont_m0_gnt_c%0d", c), {31'd0, bus.m0_gnt}, {31'd0, exp0});
            checkOutput($sformatf("cont_m1_gnt_c%0d", c), {31'd0, bus.m1_gnt}, {31'd0, exp1});
        end
        releaseReq(1'b0);
        tick();
        checkOutput("drop_idle_m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
        tick();
        checkOutput("drop_m1_gnt", {31'd0, bus.m1_gnt}, 32'd1);
        checkOutput("drop_addr",   {24'd0, bus.mem_address}, 32'h30);
        releaseReq(1'b1);
        tick();
        checkOutput("drop_m1_rvalid", {31'd0, bus.m1_rvalid}, 32'd1);
        checkOutput("drop_m1_rdata",  bus.m1_rdata, 32'h12345678);
        tick();

        // Reset during ISSUE abandons the read.
        applyStimulus(1'b0, 1'b0, 4'hF, 8'h10, 32'h0);
        tick();
        checkOutput("mid_gnt", {31'd0, bus.m0_gnt}, 32'd1);
        rst = 1'b1;
        releaseReq(1'b0);
        #1;
        checkQuiet("mid_async");
        tick();
        checkQuiet("mid_rst");
        rst = 1'b0;
        tick();
        checkQuiet("mid_after1");
        tick();
        checkQuiet("mid_after2");
        applyStimulus(1'b1, 1'b0, 4'hF, 8'h20, 32'h0);
        tick();
        checkOutput("post_gnt", {31'd0, bus.m1_gnt}, 32'd1);
        releaseReq(1'b1);
        tick();
        checkOutput("post_rvalid", {31'd0, bus.m1_rvalid}, 32'd1);
        checkOutput("post_rdata",  bus.m1_rdata, 32'hAABB3344);
        tick();
        checkQuiet("post_idle");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
